serial_capture16: RTL and testbench

Downstream companion of the 16-bit left-shift register. Samples the register's MSB (`dout[15]`) as an MSB-first serial stream, reassembles each 16-bit frame into a parallel word, and presents it on a valid/ready output with overrun detection. It sits between the shift register and the word-consuming logic.

---
 rtl/serial_capture16_pkg.sv | 20 ++
 rtl/serial_capture16_if.sv | 44 ++++
 rtl/serial_capture16_outbuf.sv | 78 +++++++
 rtl/serial_capture16.sv | 94 +++++++++
 tb/tb_serial_capture16.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_capture16_pkg.sv
// rtl/serial_capture16_pkg.sv - shared types and sizing helpers for serial_capture16
//
// Contents:
//   sercap_state_t    : capture FSM states (IDLE, SHIFT)
//   sercap_cnt_width  : bit-counter width for a given frame length
package serial_capture_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sercap_state_t;

  localparam int SERCAP_DEFAULT_WIDTH = 16;

  // Counter must hold 0..WIDTH-1; keep at least one bit for tiny frames.
  function automatic int sercap_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_capture16_if.sv
// rtl/serial_capture16_if.sv - serial input / parallel word output bundle
//
// Signals:
//   i_sdi      : serial data, MSB first
//   i_start    : frame strobe, marks frame bit WIDTH-1
//   i_ready    : consumer accepts o_data when o_valid & i_ready
//   i_ovf_clr  : synchronous clear of o_ovf
//   o_data     : assembled word
//   o_valid    : o_data holds an unconsumed word
//   o_busy     : frame in progress
//   o_ovf      : sticky overrun flag
//   o_parity   : XOR of o_data (only with SERCAP_PARITY_EN)
// Modports: master drives i_*, slave (the capture block) drives o_*.
interface serial_capture16_if #(
  parameter int WIDTH = 16
);
  logic             i_sdi;
  logic             i_start;
  logic             i_ready;
  logic             i_ovf_clr;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_busy;
  logic             o_ovf;
`ifdef SERCAP_PARITY_EN
  logic             o_parity;
`endif

  modport master (
    output i_sdi, i_start, i_ready, i_ovf_clr,
    input  o_data, o_valid, o_busy, o_ovf
`ifdef SERCAP_PARITY_EN
    , input o_parity
`endif
  );

  modport slave (
    input  i_sdi, i_start, i_ready, i_ovf_clr,
    output o_data, o_valid, o_busy, o_ovf
`ifdef SERCAP_PARITY_EN
    , output o_parity
`endif
  );
endinterface

// File: rtl/serial_capture16_outbuf.sv
// rtl/serial_capture16_outbuf.sv - single-entry output holding register with overrun flag
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_complete   : a frame finished this cycle, i_word holds it
//   i_word       : completed word
//   i_ready      : consumer ready
//   i_ovf_clr    : clear sticky overrun flag
//   o_data       : held word
//   o_valid      : held word not yet consumed
//   o_ovf        : sticky flag, a completed word was dropped
//   o_parity     : XOR of o_data (only with SERCAP_PARITY_EN)
module serial_capture_outbuf #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_complete,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_ovf
`ifdef SERCAP_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;
  logic             w_load;
  logic             w_ovf_set;

  // A held word may be replaced only when it is being accepted this same cycle.
  assign w_load    = i_complete & (~r_valid | i_ready);
  assign w_ovf_set = i_complete & r_valid & ~i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= i_word;
        r_valid <= 1'b1;
      end else if (r_valid & i_ready) begin
        r_valid <= 1'b0;
      end
      // Set beats clear so a drop in the clearing cycle is never lost.
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (i_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

`ifdef SERCAP_PARITY_EN
  logic r_parity;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_parity <= 1'b0;
    else if (w_load)
      r_parity <= ^i_word;
  end

  assign o_parity = r_parity;
`endif

endmodule

// File: rtl/serial_capture16.sv
// rtl/serial_capture16.sv - MSB-first serial frame capture into parallel words
//
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : serial_capture16_if.slave (i_sdi, i_start, i_ready, i_ovf_clr,
//           o_data, o_valid, o_busy, o_ovf, o_parity)
// Optional feature: SERCAP_PARITY_EN adds o_parity.
module serial_capture16
  import serial_capture_pkg::*;
#(
  parameter int WIDTH = SERCAP_DEFAULT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_capture16_if.slave    bus
);

  localparam int             CW   = sercap_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sercap_state_t    r_state;
  logic [CW-1:0]    r_cnt;
  // Only the WIDTH-1 bits already received are kept; the current i_sdi
  // completes the word combinationally on the final bit.
  logic [WIDTH-2:0] r_sreg;
  logic             r_busy;

  logic [WIDTH-1:0] w_word;
  logic             w_complete;

  assign w_word     = {r_sreg, bus.i_sdi};
  assign w_complete = (r_state == SHIFT) && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_state <= SHIFT;
            r_sreg  <= w_word[WIDTH-2:0];
            r_cnt   <= CW'(1);
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_sreg <= w_word[WIDTH-2:0];
          if (r_cnt == LAST) begin
            // Completion wins over a coincident start strobe.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (bus.i_start) begin
            // Abort: current bit becomes the new MSB; stale bits shift out.
            r_cnt <= CW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy = r_busy;

  serial_capture_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_complete (w_complete),
    .i_word     (w_word),
    .i_ready    (bus.i_ready),
    .i_ovf_clr  (bus.i_ovf_clr),
    .o_data     (bus.o_data),
    .o_valid    (bus.o_valid),
    .o_ovf      (bus.o_ovf)
`ifdef SERCAP_PARITY_EN
    ,
    .o_parity   (bus.o_parity)
`endif
  );

endmodule

// File: tb/tb_serial_capture16.sv
// tb/tb_serial_capture16.sv - self-checking bench for serial_capture16
module tb_serial_capture16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_capture16_if #(.WIDTH(16)) bus_if ();

  serial_capture16 #(.WIDTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  int tests_run = 0;
  int tests_failed = 0;
  string cur_tag = "init";

  // Reference model: frame bits collected in a queue, buffer as plain state.
  bit          q[$];
  logic        in_frame = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_par = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk({cur_tag, ".data"},  bus_if.o_data, m_data);
    chk({cur_tag, ".valid"}, 16'(bus_if.o_valid), 16'(m_valid));
    chk({cur_tag, ".busy"},  16'(bus_if.o_busy), 16'(in_frame));
    chk({cur_tag, ".ovf"},   16'(bus_if.o_ovf), 16'(m_ovf));
`ifdef SERCAP_PARITY_EN
    chk({cur_tag, ".parity"}, 16'(bus_if.o_parity), 16'(m_par));
`endif
  endtask

  task automatic cyc(input logic st, input logic sd, input logic rdy, input logic clr);
    logic        complete;
    logic        set_ovf;
    logic [15:0] w;
    bus_if.i_start   = st;
    bus_if.i_sdi     = sd;
    bus_if.i_ready   = rdy;
    bus_if.i_ovf_clr = clr;
    complete = 1'b0;
    if (in_frame) begin
      if (q.size() == 15) begin
        q.push_back(sd);
        complete = 1'b1;
        in_frame = 1'b0;
      end else if (st) begin
        q.delete();
        q.push_back(sd);
      end else begin
        q.push_back(sd);
      end
    end else if (st) begin
      in_frame = 1'b1;
      q.delete();
      q.push_back(sd);
    end
    w = '0;
    if (complete) foreach (q[i]) w = {w[14:0], q[i]};
    set_ovf = complete && m_valid && !rdy;
    if (complete) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_valid = 1'b1;
        m_par   = ^w;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (clr && !set_ovf) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.i_start = 1'b0;
    bus_if.i_sdi = 1'b0;
    bus_if.i_ready = 1'b0;
    bus_if.i_ovf_clr = 1'b0;
    q.delete();
    in_frame = 1'b0;
    m_data = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_par = 1'b0;
    #1;
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy_mid, input logic rdy_last,
                           input logic clr_last, input logic st_last);
    for (int i = 15; i >= 0; i--) begin
      cyc((i == 15) ? 1'b1 : ((i == 0) ? st_last : 1'b0), w[i],
          (i == 0) ? rdy_last : rdy_mid, (i == 0) ? clr_last : 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(1)), rdy, 1'b0);
  endtask

  initial begin
    bus_if.i_start = 1'b0;
    bus_if.i_sdi = 1'b0;
    bus_if.i_ready = 1'b0;
    bus_if.i_ovf_clr = 1'b0;

    cur_tag = "reset";
    do_reset();

    cur_tag = "reset_mid";
    cyc(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
    chk("mid_busy", 16'(bus_if.o_busy), 16'd1);
    do_reset();
    chk("rst_busy", 16'(bus_if.o_busy), 16'd0);

    cur_tag = "single";
    send_word(16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("single_data", bus_if.o_data, 16'hA5C3);
    chk("single_valid", 16'(bus_if.o_valid), 16'd1);
`ifdef SERCAP_PARITY_EN
    chk("single_par", 16'(bus_if.o_parity), 16'd0);
`endif

    cur_tag = "b2b";
    send_word(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b2b_data0", bus_if.o_data, 16'h0001);
`ifdef SERCAP_PARITY_EN
    chk("b2b_par0", 16'(bus_if.o_parity), 16'd1);
`endif
    send_word(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b2b_data1", bus_if.o_data, 16'hFFFF);
    chk("b2b_valid1", 16'(bus_if.o_valid), 16'd1);
`ifdef SERCAP_PARITY_EN
    chk("b2b_par1", 16'(bus_if.o_parity), 16'd0);
`endif
    idle(2, 1'b1);

    cur_tag = "overrun";
    send_word(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_data", bus_if.o_data, 16'h1234);
    chk("ovr_flag", 16'(bus_if.o_ovf), 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_valid_clr", 16'(bus_if.o_valid), 16'd0);
    chk("ovr_flag_clr", 16'(bus_if.o_ovf), 16'd0);

    cur_tag = "restart";
    cyc(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_data", bus_if.o_data, 16'hBEEF);
    chk("restart_ovf", 16'(bus_if.o_ovf), 16'd0);
    idle(1, 1'b1);

    cur_tag = "accept_complete";
    send_word(16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(16'h5500, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ac_valid", 16'(bus_if.o_valid), 16'd1);
    chk("ac_data", bus_if.o_data, 16'h5500);
    chk("ac_ovf", 16'(bus_if.o_ovf), 16'd0);
    idle(1, 1'b1);

    cur_tag = "ovf_set_vs_clr";
    send_word(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("setclr_ovf", 16'(bus_if.o_ovf), 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    cur_tag = "start_on_last";
    send_word(16'h3333, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sol_busy", 16'(bus_if.o_busy), 16'd0);
    chk("sol_data", bus_if.o_data, 16'h3333);
    idle(2, 1'b1);

    cur_tag = "random";
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(9) == 0), 1'($urandom_range(1)),
          ($urandom_range(3) != 0), ($urandom_range(15) == 0));
    end

    cur_tag = "random_frames";
    for (int n = 0; n < 40; n++) begin
      send_word(16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
